// File: rtl/handshake_master.sv
// Transmitter end of the valid/ready channel: push port -> FIFO -> held output register.
// Optional stall watchdog enabled by defining HS_MASTER_TIMEOUT_EN.
module handshake_master #(
    parameter int wd    = 4,
    parameter int depth = 4,
    parameter int tmo   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [wd-1:0]           wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(depth):0]  count,
    output logic                    m_valid,
    output logic [wd-1:0]           data_out,
    input  logic                    s_ready,
    output logic [7:0]              sent_cnt,
    output logic                    timeout
);

    localparam int CW = $clog2(depth) + 1;
    localparam int PW = $clog2(depth);
    localparam int SD = depth - 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [wd-1:0]     data_q, data_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [7:0]        sent_q, sent_d;
    logic [wd-1:0]     mem_q [SD];

    logic              push;
    logic              xfer;
    logic              load;
    logic              stor_avail;
    logic              mem_we;

    // Storage has depth-1 slots, which is not a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(SD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign m_valid  = (state_q == SEND);
    assign data_out = data_q;
    assign count    = count_q;
    assign full     = (count_q == CW'(depth));
    assign empty    = (count_q == '0);
    assign sent_cnt = sent_q;

    assign push       = wr_en && !full;
    assign xfer       = m_valid && s_ready;
    assign load       = !m_valid || xfer;
    assign stor_avail = m_valid ? (count_q > CW'(1)) : (count_q != '0);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        sent_d   = sent_q;
        mem_we   = 1'b0;

        if (xfer) begin
            sent_d = sent_q + 8'd1;
        end

        if (load) begin
            if (stor_avail) begin
                data_d   = mem_q[rd_ptr_q];
                rd_ptr_d = ptr_inc(rd_ptr_q);
                state_d  = SEND;
                mem_we   = push;
            end else if (push) begin
                // Nothing buffered: a same-cycle push bypasses storage into the output register.
                data_d  = wr_data;
                state_d = SEND;
            end else begin
                state_d = IDLE;
            end
        end else begin
            mem_we = push;
        end

        if (mem_we) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (push && !xfer) begin
            count_d = count_q + CW'(1);
        end else if (!push && xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            sent_q   <= sent_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef HS_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(tmo + 1);

    logic [TW-1:0] stall_q, stall_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        stall_d = stall_q;
        if (xfer) begin
            stall_d = '0;
        end else if (m_valid && (stall_q != TW'(tmo))) begin
            stall_d = stall_q + TW'(1);
        end
        timeout_d = timeout_q || (stall_d == TW'(tmo));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    localparam int unused_tmo = tmo;

    assign timeout = 1'b0;
`endif

endmodule
